// File: rtl/audio_avg_filter.sv
// audio_avg_filter: codec-driven per-channel box-car low-pass over 2**LOG2_TAPS samples.
// Optional `AUDIO_AVG_BYPASS_EN adds a 'bypass' input that passes raw samples through.
module audio_avg_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
`ifdef AUDIO_AVG_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = DATA_W + LOG2_TAPS;
  typedef enum logic [2:0] {IDLE, READ, CALC, WAIT, WRITE} state_t;
  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   samp_l_q, samp_r_q;
  logic signed [DATA_W-1:0]   hist_l_q [TAPS];
  logic signed [DATA_W-1:0]   hist_r_q [TAPS];
  logic signed [SW-1:0]       sum_l_q, sum_r_q, sum_l_d, sum_r_d;
  logic [LOG2_TAPS-1:0]       ptr_q;
  logic signed [DATA_W-1:0]   wd_l_q, wd_r_q, wd_l_d, wd_r_d;
  logic                       pass;
`ifdef AUDIO_AVG_BYPASS_EN
  assign pass = bypass;
`else
  assign pass = 1'b0;
`endif
  assign read            = state_q == READ;
  assign write           = state_q == WRITE;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  always_comb begin
    state_d = state_q == IDLE ? (read_ready ? READ : IDLE) :
              state_q == READ ? CALC :
              state_q == CALC ? WAIT :
              state_q == WAIT ? (write_ready ? WRITE : WAIT) : IDLE;
    sum_l_d = sum_l_q + SW'(samp_l_q) - SW'(hist_l_q[ptr_q]);
    sum_r_d = sum_r_q + SW'(samp_r_q) - SW'(hist_r_q[ptr_q]);
    // sum is wide enough that the shifted result always fits back in DATA_W
    wd_l_d  = pass ? samp_l_q : DATA_W'(sum_l_d >>> LOG2_TAPS);
    wd_r_d  = pass ? samp_r_q : DATA_W'(sum_r_d >>> LOG2_TAPS);
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      samp_l_q <= '0;
      samp_r_q <= '0;
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      ptr_q    <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_l_q[i] <= '0;
        hist_r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == READ) begin
        samp_l_q <= readdata_left;
        samp_r_q <= readdata_right;
      end
      if (state_q == CALC) begin
        hist_l_q[ptr_q] <= samp_l_q;
        hist_r_q[ptr_q] <= samp_r_q;
        sum_l_q         <= sum_l_d;
        sum_r_q         <= sum_r_d;
        wd_l_q          <= wd_l_d;
        wd_r_q          <= wd_r_d;
        ptr_q           <= ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_avg_filter.sv
// tb_audio_avg_filter: scoreboard bench; u0 uses a 4-tap window, u1 an 8-tap window.
module tb_audio_avg_filter;
  typedef struct packed {logic signed [23:0] l; logic signed [23:0] r;} pair_t;
  logic clk, rst;
  logic rr [2];
  logic wr [2];
  logic rd [2];
  logic wt [2];
  logic signed [23:0] dl [2];
  logic signed [23:0] dr [2];
  logic signed [23:0] ol [2];
  logic signed [23:0] orr [2];
  pair_t q0[$], q1[$];
  int total = 0, bad = 0;
`ifdef AUDIO_AVG_BYPASS_EN
  logic bp = 1'b0;
`endif
  audio_avg_filter #(.DATA_W(24), .LOG2_TAPS(2)) u0 (
    .CLOCK_50(clk), .reset(rst),
`ifdef AUDIO_AVG_BYPASS_EN
    .bypass(bp),
`endif
    .read_ready(rr[0]), .write_ready(wr[0]),
    .readdata_left(dl[0]), .readdata_right(dr[0]),
    .read(rd[0]), .write(wt[0]),
    .writedata_left(ol[0]), .writedata_right(orr[0]));
  audio_avg_filter #(.DATA_W(24), .LOG2_TAPS(3)) u1 (
    .CLOCK_50(clk), .reset(rst),
`ifdef AUDIO_AVG_BYPASS_EN
    .bypass(1'b0),
`endif
    .read_ready(rr[1]), .write_ready(wr[1]),
    .readdata_left(dl[1]), .readdata_right(dr[1]),
    .read(rd[1]), .write(wt[1]),
    .writedata_left(ol[1]), .writedata_right(orr[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic signed [23:0] a, input logic signed [23:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask
  task automatic mon(input int d);
    pair_t p;
    if (rd[d] || wt[d]) chk($sformatf("proto%0d_rd_and_wr", d), 24'(rd[d] & wt[d]), 24'sd0);
    if (wt[d]) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write%0d got=write exp=none", d);
      end else begin
        p = d == 0 ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out%0d_left", d), ol[d], p.l);
        chk($sformatf("out%0d_right", d), orr[d], p.r);
      end
    end
  endtask
  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);
  task automatic send(input int d, input logic signed [23:0] l, input logic signed [23:0] r,
                      input logic signed [23:0] el, input logic signed [23:0] er, input bit push);
    pair_t p;
    bit ok;
    @(negedge clk);
    dl[d] = l;
    dr[d] = r;
    rr[d] = 1'b1;
    p.l = el;
    p.r = er;
    if (push) begin
      if (d == 0) q0.push_back(p);
      else q1.push_back(p);
    end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rd[d];
    end
    rr[d] = 1'b0;
    if (!ok) chk("read_timeout", 24'sd0, 24'sd1);
  endtask
  task automatic drain;
    for (int i = 0; i < 200 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    if ((q0.size() + q1.size()) != 0) chk("drain_timeout", 24'(q0.size() + q1.size()), 24'sd0);
  endtask
  task automatic do_reset;
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rr[d] = 1'b0;
      wr[d] = 1'b1;
      dl[d] = '0;
      dr[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_read", 24'(rd[d]), 24'sd0);
      chk("reset_write", 24'(wt[d]), 24'sd0);
      chk("reset_wd_left", ol[d], 24'sd0);
      chk("reset_wd_right", orr[d], 24'sd0);
    end
    rst = 1'b0;
    // constant input ramps up over the 4-tap window
    send(0, 400, -800, 100, -200, 1);
    send(0, 400, -800, 200, -400, 1);
    send(0, 400, -800, 300, -600, 1);
    send(0, 400, -800, 400, -800, 1);
    send(0, 400, -800, 400, -800, 1);
    // -1 >>> 2 floors to -1 until it falls out of the window
    do_reset();
    send(0, -1, 0, -1, 0, 1);
    send(0, 0, 0, -1, 0, 1);
    send(0, 0, 0, -1, 0, 1);
    send(0, 0, 0, -1, 0, 1);
    send(0, 0, 0, 0, 0, 1);
    // stall in WAIT with read_ready high
    drain();
    wr[0] = 1'b0;
    send(0, 40, -40, 10, -10, 1);
    @(negedge clk);
    rr[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_read", 24'(rd[0]), 24'sd0);
      chk("stall_write", 24'(wt[0]), 24'sd0);
      chk("stall_left", ol[0], 24'sd10);
      chk("stall_right", orr[0], -24'sd10);
    end
    rr[0] = 1'b0;
    wr[0] = 1'b1;
    @(negedge clk);
    chk("release_write", 24'(wt[0]), 24'sd1);
    @(negedge clk);
    chk("release_write_once", 24'(wt[0]), 24'sd0);
    // async reset while a result waits
    do_reset();
    send(0, 400, -800, 100, -200, 1);
    send(0, 400, -800, 200, -400, 1);
    drain();
    wr[0] = 1'b0;
    send(0, 400, -800, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("wait_left", ol[0], 24'sd300);
    chk("wait_right", orr[0], -24'sd600);
    #2 rst = 1'b1;
    #1;
    chk("async_read", 24'(rd[0]), 24'sd0);
    chk("async_write", 24'(wt[0]), 24'sd0);
    chk("async_left", ol[0], 24'sd0);
    chk("async_right", orr[0], 24'sd0);
    @(negedge clk);
    rst = 1'b0;
    wr[0] = 1'b1;
    send(0, 400, -800, 100, -200, 1);
`ifdef AUDIO_AVG_BYPASS_EN
    do_reset();
    bp = 1'b1;
    send(0, 4, -4, 4, -4, 1);
    send(0, 8, -8, 8, -8, 1);
    drain();
    bp = 1'b0;
    send(0, 12, -12, 6, -6, 1);
`endif
    // full-scale inputs on the 8-tap instance
    send(1, 24'sd8388607, -24'sd8388608, 24'sd1048575, -24'sd1048576, 1);
    send(1, 24'sd8388607, -24'sd8388608, 24'sd2097151, -24'sd2097152, 1);
    send(1, 24'sd8388607, -24'sd8388608, 24'sd3145727, -24'sd3145728, 1);
    send(1, 24'sd8388607, -24'sd8388608, 24'sd4194303, -24'sd4194304, 1);
    send(1, 24'sd8388607, -24'sd8388608, 24'sd5242879, -24'sd5242880, 1);
    send(1, 24'sd8388607, -24'sd8388608, 24'sd6291455, -24'sd6291456, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
